// File: rtl/bram_block_pkg.sv
// bram_block_pkg
// Shared constants and width helpers for the BRAM block buffer and the
// producer/consumer stages that talk to it.
//   BRAM_READ_LATENCY : cycles from read accept to read_block_valid_out
//   ptr_width()       : bits needed to index n entries (min 1)
//   count_width()     : bits needed to hold a count 0..n
package bram_block_pkg;

  localparam int BRAM_READ_LATENCY = 2;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bram_slot_ptr.sv
// bram_slot_ptr
// Block index + slot pointer pair addressing one side of the block buffer.
// Ports:
//   clk, rst    : clock, async active-high reset
//   accept      : one block consumed/produced this cycle; advance the index
//   rewind      : return the block index to 0 (slot unchanged); wins over accept
//   block_idx   : current block index inside the slot
//   slot_ptr    : current slot
//   last_block  : block_idx is the final block of the slot
module bram_slot_ptr
  import bram_block_pkg::*;
#(
  parameter int NUM_BLOCKS = 128,
  parameter int NUM_SLOTS  = 2
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  accept,
  input  logic                                  rewind,
  output logic [ptr_width(NUM_BLOCKS)-1:0]      block_idx,
  output logic [ptr_width(NUM_SLOTS)-1:0]       slot_ptr,
  output logic                                  last_block
);

  localparam int BW = ptr_width(NUM_BLOCKS);
  localparam int SW = ptr_width(NUM_SLOTS);

  logic [BW-1:0] block_idx_r;
  logic [SW-1:0] slot_ptr_r;
  logic          last_block_s;

  assign last_block_s = (block_idx_r == BW'(NUM_BLOCKS - 1));

  // Index/slot advance; sizes are powers of two so plain increments wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      block_idx_r <= '0;
      slot_ptr_r  <= '0;
    end else if (rewind) begin
      block_idx_r <= '0;
      slot_ptr_r  <= slot_ptr_r;
    end else if (accept) begin
      if (last_block_s) begin
        block_idx_r <= '0;
        slot_ptr_r  <= slot_ptr_r + SW'(1'b1);
      end else begin
        block_idx_r <= block_idx_r + BW'(1'b1);
        slot_ptr_r  <= slot_ptr_r;
      end
    end else begin
      block_idx_r <= block_idx_r;
      slot_ptr_r  <= slot_ptr_r;
    end
  end

  assign block_idx  = block_idx_r;
  assign slot_ptr   = slot_ptr_r;
  assign last_block = last_block_s;

endmodule

// File: rtl/bram_block_buffer.sv
// bram_block_buffer
// Multi-slot block buffer for multi-word operands. A writer fills whole
// slots of NUM_BLOCKS blocks; a reader drains completed slots in FIFO order
// with a 2-cycle read latency. Rewind restarts the head slot at block 0.
// Ports:
//   clk_in, rst_in            : clock, async active-high reset
//   write_block_valid_in/_in  : write one block (dropped when not ready)
//   write_ready_out           : a free slot exists
//   write_slot_done_out       : 1-cycle pulse after a slot is completed
//   read_next_block_valid_in  : request next block of the head slot
//   read_rewind_in            : restart head-slot read index at 0
//   read_ready_out            : at least one full slot available
//   read_block_out/_valid_out : read data (0 when not valid)
//   read_last_out             : final block of a slot
//   slots_full_count_out      : completed, unread slots
module bram_block_buffer
  import bram_block_pkg::*;
#(
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_BLOCKS    = 128,
  parameter int NUM_SLOTS     = 2
) (
  input  logic                               clk_in,
  input  logic                               rst_in,
  input  logic                               write_block_valid_in,
  input  logic [REGISTER_SIZE-1:0]           write_block_in,
  output logic                               write_ready_out,
  output logic                               write_slot_done_out,
  input  logic                               read_next_block_valid_in,
  input  logic                               read_rewind_in,
  output logic                               read_ready_out,
  output logic [REGISTER_SIZE-1:0]           read_block_out,
  output logic                               read_block_valid_out,
  output logic                               read_last_out,
  output logic [$clog2(NUM_SLOTS+1)-1:0]     slots_full_count_out
);

  localparam int BW    = ptr_width(NUM_BLOCKS);
  localparam int SW    = ptr_width(NUM_SLOTS);
  localparam int CW    = count_width(NUM_SLOTS);
  localparam int AW    = SW + BW;
  localparam int DEPTH = NUM_SLOTS * NUM_BLOCKS;

  // Pointer state
  logic [BW-1:0] wr_idx_s;
  logic [SW-1:0] wr_slot_s;
  logic          wr_last_s;
  logic [BW-1:0] rd_idx_s;
  logic [SW-1:0] rd_slot_s;
  logic          rd_last_s;

  // Handshakes
  logic          wr_accept_s;
  logic          rd_accept_s;
  logic          wr_done_s;
  logic          rd_free_s;
  logic          read_ready_s;
  logic [CW-1:0] count_next_s;

  // Registered state / outputs
  logic [CW-1:0]            full_count_r;
  logic                     write_ready_r;
  logic                     write_slot_done_r;
  logic                     rd_valid_p1_r;
  logic                     rd_last_p1_r;
  logic [REGISTER_SIZE-1:0] ram_q_r;
  logic [REGISTER_SIZE-1:0] read_block_r;
  logic                     read_valid_r;
  logic                     read_last_r;

  // Storage: port A read-only, port B write-only
  logic [REGISTER_SIZE-1:0] mem_r [DEPTH];
  logic [AW-1:0]            wr_addr_s;
  logic [AW-1:0]            rd_addr_s;

  assign read_ready_s = (full_count_r != '0);
  assign wr_accept_s  = write_block_valid_in & write_ready_r;
  // Rewind takes precedence: a request in the rewind cycle is not accepted.
  assign rd_accept_s  = read_next_block_valid_in & read_ready_s & ~read_rewind_in;
  assign wr_done_s    = wr_accept_s & wr_last_s;
  // The slot is released when its last block is requested, not when the
  // data returns; the writer cannot reach it before index 0, so no clash.
  assign rd_free_s    = rd_accept_s & rd_last_s;
  assign wr_addr_s    = {wr_slot_s, wr_idx_s};
  assign rd_addr_s    = {rd_slot_s, rd_idx_s};

  bram_slot_ptr #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_wr_ptr (
    .clk        (clk_in),
    .rst        (rst_in),
    .accept     (wr_accept_s),
    .rewind     (1'b0),
    .block_idx  (wr_idx_s),
    .slot_ptr   (wr_slot_s),
    .last_block (wr_last_s)
  );

  bram_slot_ptr #(
    .NUM_BLOCKS (NUM_BLOCKS),
    .NUM_SLOTS  (NUM_SLOTS)
  ) u_rd_ptr (
    .clk        (clk_in),
    .rst        (rst_in),
    .accept     (rd_accept_s),
    .rewind     (read_rewind_in),
    .block_idx  (rd_idx_s),
    .slot_ptr   (rd_slot_s),
    .last_block (rd_last_s)
  );

  // Next full-slot count; simultaneous complete and free cancel out.
  always_comb begin
    count_next_s = full_count_r;
    case ({wr_done_s, rd_free_s})
      2'b10:   count_next_s = full_count_r + CW'(1'b1);
      2'b01:   count_next_s = full_count_r - CW'(1'b1);
      default: count_next_s = full_count_r;
    endcase
  end

  // Occupancy, write-side flow control and slot-done pulse.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      full_count_r      <= '0;
      write_ready_r     <= 1'b0;
      write_slot_done_r <= 1'b0;
    end else begin
      full_count_r      <= count_next_s;
      write_ready_r     <= (count_next_s < CW'(NUM_SLOTS));
      write_slot_done_r <= wr_done_s;
    end
  end

  // BRAM port B: write-only.
  always_ff @(posedge clk_in) begin
    if (wr_accept_s) begin
      mem_r[wr_addr_s] <= write_block_in;
    end
  end

  // BRAM port A: read-only, registered read (first latency stage).
  always_ff @(posedge clk_in) begin
    if (rd_accept_s) begin
      ram_q_r <= mem_r[rd_addr_s];
    end else begin
      ram_q_r <= ram_q_r;
    end
  end

  // Valid/last tracking and output register (second latency stage).
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rd_valid_p1_r <= 1'b0;
      rd_last_p1_r  <= 1'b0;
      read_valid_r  <= 1'b0;
      read_last_r   <= 1'b0;
      read_block_r  <= '0;
    end else begin
      rd_valid_p1_r <= rd_accept_s;
      rd_last_p1_r  <= rd_accept_s & rd_last_s;
      read_valid_r  <= rd_valid_p1_r;
      read_last_r   <= rd_valid_p1_r & rd_last_p1_r;
      read_block_r  <= rd_valid_p1_r ? ram_q_r : '0;
    end
  end

  assign write_ready_out      = write_ready_r;
  assign write_slot_done_out  = write_slot_done_r;
  assign read_ready_out       = read_ready_s;
  assign read_block_out       = read_block_r;
  assign read_block_valid_out = read_valid_r;
  assign read_last_out        = read_last_r;
  assign slots_full_count_out = full_count_r;

endmodule
